pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the five-stage Y86 processor.
- Watches the instruction in decode and the instruction in execute.
- Drives stall and bubble controls to fetch, decode and execute registers.
- Resolves load-use hazards, branch mispredicts, `ret` and `halt` with a small FSM plus a bubble counter; keeps a saturating stall-cycle counter for debug.

Parameters:
- RET_BUBBLES, 3, number of cycles fetch is held after a `ret` leaves decode (ret reaches memory stage).
- CNT_W, 2, width of the ret bubble counter; must hold RET_BUBBLES.
- PERF_W, 16, width of the saturating stall-cycle counter.

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- d_icode  in  4  icode of instruction currently in decode
- d_srcA  in  4  register ID decode reads as A; 4'hF = none
- d_srcB  in  4  register ID decode reads as B; 4'hF = none
- e_icode  in  4  icode of instruction currently in execute
- e_dstM  in  4  memory-load destination of execute instruction; 4'hF = none
- e_cnd  in  1  actual branch condition computed in execute
- e_pred  in  1  prediction carried with the execute instruction (1 = taken)
- stall_f  out  1  hold fetch PC register
- stall_d  out  1  hold decode pipeline register
- bubble_d  out  1  load nop (icode 1) into decode register
- bubble_e  out  1  load nop into execute register
- ret_busy  out  1  FSM in RET_WAIT
- halted  out  1  FSM in HALTED
- stall_cycles  out  PERF_W  count of cycles with stall_f = 1, saturating

Behaviour:
- Reset (async, any time including mid-RET_WAIT):
  - state = RUN, ret counter = 0, stall_cycles = 0.
  - All control outputs 0 while reset is asserted.
- Control outputs are combinational from state plus current inputs. State, counter and stall_cycles update on the rising clock edge.
- Event definitions:
  - mispredict: e_icode == 7 and e_cnd != e_pred.
  - load_use: e_icode in {5, 0xB}, e_dstM != 4'hF, and e_dstM equals d_srcA or d_srcB (a 4'hF source never matches).
  - ret_d: d_icode == 9.
  - halt_d: d_icode == 0.
- State RUN, priority highest first (only one branch applies):
  - mispredict: bubble_d = 1, bubble_e = 1; stay RUN. The wrong-path ret or halt in decode is discarded and does not trigger.
  - load_use: stall_f = 1, stall_d = 1, bubble_e = 1; stay RUN. A ret or halt in decode waits, then triggers in a later cycle.
  - ret_d: stall_f = 1, bubble_d = 1; go to RET_WAIT, counter = RET_BUBBLES-1.
  - halt_d: stall_f = 1, bubble_d = 1; go to HALTED.
  - Otherwise all controls 0.
- State RET_WAIT:
  - stall_f = 1, bubble_d = 1 every cycle.
  - Counter decrements each cycle; leave for RUN in the cycle the counter is 0.
  - Total cycles with stall_f = 1 for one ret = RET_BUBBLES.
  - A mispredict seen in RET_WAIT forces RUN next cycle with counter cleared; outputs that cycle follow the mispredict rule.
- State HALTED:
  - stall_f = 1, bubble_d = 1 permanently; only reset exits.
  - halted = 1.
- stall_cycles increments each cycle stall_f = 1 and holds at all-ones.
- Two ret instructions back-to-back: the second is held by the bubbles and only enters decode after RUN resumes; it is handled as a fresh ret_d.

Test Plan:
- Load-use: e_icode = 5, e_dstM = 3, d_srcA = 3 -> stall_f = stall_d = bubble_e = 1, bubble_d = 0. Next cycle with e_icode = 1 -> all controls 0.
- Mispredict overrides ret: e_icode = 7, e_cnd = 0, e_pred = 1, d_icode = 9 -> bubble_d = bubble_e = 1, stall_f = 0, state stays RUN (ret_busy = 0).
- Ret sequence: d_icode = 9 for one cycle, then d_icode = 1 -> stall_f = 1 and bubble_d = 1 for exactly 3 consecutive cycles. ret_busy = 1 for the last 2 of them, then 0. stall_cycles = 3.
- Reset mid-ret: assert reset asynchronously in the 2nd RET_WAIT cycle -> ret_busy, stall_f and stall_cycles drop to 0 immediately. After release, the next d_icode = 1 gives no stall.
- Halt: d_icode = 0 -> halted = 1 from the next cycle and stays 1 for 100 cycles regardless of inputs. stall_cycles increments each cycle; with PERF_W = 4 it saturates at 15.
- Source 4'hF never matches: e_icode = 0xB, e_dstM = 4'hF, d_srcA = 4'hF -> no stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: Y86 five-stage pipeline hazard control (load-use, mispredict, ret, halt) with stall-cycle counter.
// Latency: control outputs are combinational from state and current decode/execute fields; state updates on clock.
// Backpressure: none consumed; this block produces the stall/bubble backpressure for fetch, decode and execute.
module pipe_hazard_ctrl #(
    parameter int RET_BUBBLES = 3,
    parameter int CNT_W       = 2,
    parameter int PERF_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        d_icode,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    input  logic [3:0]        e_icode,
    input  logic [3:0]        e_dstM,
    input  logic              e_cnd,
    input  logic              e_pred,
    output logic              stall_f,
    output logic              stall_d,
    output logic              bubble_d,
    output logic              bubble_e,
    output logic              ret_busy,
    output logic              halted,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_RET_WAIT = 2'd1;
    localparam logic [1:0] ST_HALTED   = 2'd2;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Fetch is held once in RUN plus (RET_BUBBLES-1) cycles in RET_WAIT.
    localparam logic [CNT_W-1:0] RET_LOAD = CNT_W'(RET_BUBBLES - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    logic mispredict;
    logic load_use;
    logic ret_d;
    logic halt_d;

    logic stall_f_c, stall_d_c, bubble_d_c, bubble_e_c;

    // Hazard event decode; a load with no destination (0xF) can never match a source.
    always_comb begin
        mispredict = (e_icode == I_JXX) && (e_cnd != e_pred);
        load_use   = ((e_icode == I_MRMOVQ) || (e_icode == I_POPQ)) &&
                     (e_dstM != REG_NONE) &&
                     ((e_dstM == d_srcA) || (e_dstM == d_srcB));
        ret_d      = (d_icode == I_RET);
        halt_d     = (d_icode == I_HALT);
    end

    // Next-state and control decode; mispredict outranks everything so wrong-path ret/halt are dropped.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_f_c  = 1'b0;
        stall_d_c  = 1'b0;
        bubble_d_c = 1'b0;
        bubble_e_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mispredict) begin
                    bubble_d_c = 1'b1;
                    bubble_e_c = 1'b1;
                end else if (load_use) begin
                    stall_f_c  = 1'b1;
                    stall_d_c  = 1'b1;
                    bubble_e_c = 1'b1;
                end else if (ret_d) begin
                    stall_f_c  = 1'b1;
                    bubble_d_c = 1'b1;
                    if (RET_BUBBLES > 1) begin
                        state_d = ST_RET_WAIT;
                        cnt_d   = RET_LOAD;
                    end
                end else if (halt_d) begin
                    stall_f_c  = 1'b1;
                    bubble_d_c = 1'b1;
                    state_d    = ST_HALTED;
                end
            end
            ST_RET_WAIT: begin
                if (mispredict) begin
                    bubble_d_c = 1'b1;
                    bubble_e_c = 1'b1;
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                end else begin
                    stall_f_c  = 1'b1;
                    bubble_d_c = 1'b1;
                    cnt_d      = cnt_q - CNT_W'(1);
                    // Last wait cycle: counter reaches zero as we hand back to RUN.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_HALTED: begin
                stall_f_c  = 1'b1;
                bubble_d_c = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Controls are forced quiet while reset is held, regardless of inputs.
    always_comb begin
        stall_f  = stall_f_c  & ~reset;
        stall_d  = stall_d_c  & ~reset;
        bubble_d = bubble_d_c & ~reset;
        bubble_e = bubble_e_c & ~reset;
        ret_busy = (state_q == ST_RET_WAIT) & ~reset;
        halted   = (state_q == ST_HALTED) & ~reset;
        stall_cycles = stall_cycles_q;
    end

    // Saturating debug count of fetch-stall cycles.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_f && (stall_cycles_q != {PERF_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    // State, ret counter and perf counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: self-checking bench for pipe_hazard_ctrl using an expected-result queue.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: not applicable; bench drives every cycle.
module tb_pipe_hazard_ctrl;

    localparam int PERF_W = 4;

    logic              clock;
    logic              reset;
    logic [3:0]        d_icode, d_srcA, d_srcB, e_icode, e_dstM;
    logic              e_cnd, e_pred;
    logic              stall_f, stall_d, bubble_d, bubble_e, ret_busy, halted;
    logic [PERF_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]        ctl;   // {stall_f, stall_d, bubble_d, bubble_e, ret_busy, halted}
        logic [PERF_W-1:0] sc;
        string             tag;
    } exp_t;

    exp_t exp_q[$];

    pipe_hazard_ctrl #(.RET_BUBBLES(3), .CNT_W(2), .PERF_W(PERF_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .d_icode      (d_icode),
        .d_srcA       (d_srcA),
        .d_srcB       (d_srcB),
        .e_icode      (e_icode),
        .e_dstM       (e_dstM),
        .e_cnd        (e_cnd),
        .e_pred       (e_pred),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .bubble_d     (bubble_d),
        .bubble_e     (bubble_e),
        .ret_busy     (ret_busy),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] ei, input logic [3:0] edm,
                         input logic cnd, input logic pred);
        d_icode = di; d_srcA = sa; d_srcB = sb;
        e_icode = ei; e_dstM = edm; e_cnd = cnd; e_pred = pred;
    endtask

    task automatic push_exp(input logic [5:0] ctl, input int sc, input string tag);
        exp_t e;
        e.ctl = ctl;
        e.sc  = PERF_W'(sc);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({e.tag, "_ctl"}, {26'd0, stall_f, stall_d, bubble_d, bubble_e, ret_busy, halted}, {26'd0, e.ctl});
            check_eq({e.tag, "_sc"}, {28'd0, stall_cycles}, {28'd0, e.sc});
        end
    endtask

    // One clock cycle: drive after the edge, queue expectation, compare on the falling edge.
    task automatic step(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] ei, input logic [3:0] edm,
                        input logic cnd, input logic pred,
                        input logic [5:0] ctl, input int sc, input string tag);
        @(posedge clock);
        #1;
        drive(di, sa, sb, ei, edm, cnd, pred);
        push_exp(ctl, sc, tag);
        @(negedge clock);
        pop_check();
    endtask

    task automatic idle(input logic [5:0] ctl, input int sc, input string tag);
        step(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 1'b0, ctl, sc, tag);
    endtask

    //                      sf sd bd be rb h
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_MIS  = 6'b001100;
    localparam logic [5:0] C_RET0 = 6'b101000;
    localparam logic [5:0] C_RETW = 6'b101010;
    localparam logic [5:0] C_MISW = 6'b001110;
    localparam logic [5:0] C_HALT = 6'b101001;

    initial begin
        // Reset held with a halt in decode: every control must stay low.
        reset = 1'b1;
        drive(4'h0, 4'h3, 4'h3, 4'h5, 4'h3, 1'b0, 1'b0);
        push_exp(C_NONE, 0, "reset_hold");
        @(negedge clock);
        pop_check();

        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 1'b0);
        push_exp(C_NONE, 0, "post_reset");
        @(negedge clock);
        pop_check();

        // Load-use on srcA, then clears.
        step(4'h6, 4'h3, 4'h1, 4'h5, 4'h3, 1'b0, 1'b0, C_LU, 0, "lu_srcA");
        idle(C_NONE, 1, "lu_clear");
        // Load-use on srcB via popq.
        step(4'h6, 4'h2, 4'h7, 4'hB, 4'h7, 1'b0, 1'b0, C_LU, 1, "lu_srcB");
        // 0xF destination/sources never match.
        step(4'h6, 4'hF, 4'hF, 4'hB, 4'hF, 1'b0, 1'b0, C_NONE, 2, "none_nomatch");
        // Load-use with a different register does not stall.
        step(4'h6, 4'h1, 4'h2, 4'h5, 4'h3, 1'b0, 1'b0, C_NONE, 2, "lu_diff_reg");

        // Ret held by load-use, then triggers; three stall cycles total.
        step(4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 1'b0, C_LU, 2, "ret_under_lu");
        step(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 1'b0, C_RET0, 3, "ret_start");
        idle(C_RETW, 4, "ret_wait1");
        idle(C_RETW, 5, "ret_wait2");
        idle(C_NONE, 6, "ret_done");

        // Mispredict squashes a wrong-path ret; stays RUN.
        step(4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 1'b1, C_MIS, 6, "mis_over_ret");
        idle(C_NONE, 6, "mis_stay_run");

        // Mispredict during RET_WAIT returns to RUN.
        step(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 1'b0, C_RET0, 6, "ret2_start");
        step(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 1'b0, C_MISW, 7, "mis_in_wait");
        idle(C_NONE, 7, "mis_wait_run");

        // Asynchronous reset in the second RET_WAIT cycle.
        step(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 1'b0, C_RET0, 7, "ret3_start");
        idle(C_RETW, 8, "ret3_wait1");
        idle(C_RETW, 9, "ret3_wait2");
        #1;
        reset = 1'b1;
        push_exp(C_NONE, 0, "async_reset");
        #1;
        pop_check();
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 1'b0);
        push_exp(C_NONE, 0, "reset_release");
        @(negedge clock);
        pop_check();
        idle(C_NONE, 0, "after_reset_run");

        // Halt: sticky for 100 cycles under random inputs; perf counter saturates.
        step(4'h0, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 1'b0, C_RET0, 0, "halt_start");
        for (int i = 0; i < 100; i++) begin
            step(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), C_HALT, (i + 1 > 15) ? 15 : i + 1, "halted");
        end

        // Reset leaves HALTED.
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        push_exp(C_NONE, 0, "halt_reset_exit");
        @(negedge clock);
        pop_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
